// File: rtl/shiftreg_cfg_sequencer.sv
// Serial loader and arbiter for the static and dynamic config shift registers.
// One word at a time: capture, select, shift MSB-first, latch, then settle.
module shiftreg_cfg_sequencer #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16,
  parameter int N_SETUP    = 8,
  parameter int N_HOLD     = 128
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  stat_req,
  input  logic [SIZESRSTAT-1:0] stat_data,
  output logic                  stat_ack,
  input  logic                  dyn_req,
  input  logic [SIZESRDYN-1:0]  dyn_data,
  output logic                  dyn_ack,
  output logic                  sel_stat,
  output logic                  sel_dyn,
  output logic                  sr_sdata,
  output logic                  sr_shift_en,
  output logic                  sr_latch,
  output logic                  busy,
  output logic                  done,
  output logic                  stat_loaded
);

  localparam int MAXA = (SIZESRSTAT > N_SETUP) ? SIZESRSTAT : N_SETUP;
  localparam int MAXV = (MAXA > N_HOLD) ? MAXA : N_HOLD;
  localparam int CW   = $clog2(MAXV + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(N_SETUP - 1);
  localparam logic [CW-1:0] STAT_LAST  = CW'(SIZESRSTAT - 1);
  localparam logic [CW-1:0] DYN_LAST   = CW'(SIZESRDYN - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(N_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_LATCH,
    S_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SIZESRSTAT-1:0] shadow_q, shadow_d;
  logic                  gnt_stat_q, gnt_stat_d;
  logic                  fin_q, fin_d;
  logic                  stat_loaded_q, stat_loaded_d;

  logic stat_ack_q, stat_ack_d;
  logic dyn_ack_q, dyn_ack_d;
  logic sel_stat_q, sel_stat_d;
  logic sel_dyn_q, sel_dyn_d;
  logic sdata_q, sdata_d;
  logic shift_en_q, shift_en_d;
  logic latch_q, latch_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic loaded_eff;
  logic win_stat;
  logic active;
  logic [CW-1:0] shift_last;

  // Arbitration: static-first until a static word lands, then alternate.
  always_comb begin
    loaded_eff = stat_loaded_q | (fin_q & gnt_stat_q);
    win_stat   = stat_req;
    if (loaded_eff && stat_req && dyn_req) begin
      win_stat = ~gnt_stat_q;
    end
  end

  // Next-state, counters, shadow register and registered-output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    gnt_stat_d    = gnt_stat_q;
    fin_d         = 1'b0;
    stat_loaded_d = loaded_eff;
    stat_ack_d    = 1'b0;
    dyn_ack_d     = 1'b0;
    shift_last    = gnt_stat_q ? STAT_LAST : DYN_LAST;

    unique case (state_q)
      S_IDLE: begin
        if (stat_req || dyn_req) begin
          state_d    = S_SETUP;
          cnt_d      = '0;
          gnt_stat_d = win_stat;
          if (win_stat) begin
            shadow_d   = stat_data;
            stat_ack_d = 1'b1;
          end else begin
            shadow_d = '0;
            shadow_d[SIZESRSTAT-1 -: SIZESRDYN] = dyn_data;
            dyn_ack_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        shadow_d = shadow_q << 1;
        if (cnt_q == shift_last) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          fin_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    active     = (state_q == S_SETUP) ||
                 (state_q == S_SHIFT) ||
                 (state_q == S_LATCH);
    sel_stat_d = active & gnt_stat_q;
    sel_dyn_d  = active & ~gnt_stat_q;
    sdata_d    = ((state_q == S_SETUP) ||
                  (state_q == S_SHIFT)) &
                 shadow_q[SIZESRSTAT-1];
    shift_en_d = (state_q == S_SHIFT);
    latch_d    = (state_q == S_LATCH);
    busy_d     = (state_q != S_IDLE);
    done_d     = fin_q;
  end

  // State and output registers with synchronous abort on reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      shadow_q      <= '0;
      gnt_stat_q    <= 1'b0;
      fin_q         <= 1'b0;
      stat_loaded_q <= 1'b0;
      stat_ack_q    <= 1'b0;
      dyn_ack_q     <= 1'b0;
      sel_stat_q    <= 1'b0;
      sel_dyn_q     <= 1'b0;
      sdata_q       <= 1'b0;
      shift_en_q    <= 1'b0;
      latch_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      gnt_stat_q    <= gnt_stat_d;
      fin_q         <= fin_d;
      stat_loaded_q <= stat_loaded_d;
      stat_ack_q    <= stat_ack_d;
      dyn_ack_q     <= dyn_ack_d;
      sel_stat_q    <= sel_stat_d;
      sel_dyn_q     <= sel_dyn_d;
      sdata_q       <= sdata_d;
      shift_en_q    <= shift_en_d;
      latch_q       <= latch_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign stat_ack    = stat_ack_q;
  assign dyn_ack     = dyn_ack_q;
  assign sel_stat    = sel_stat_q;
  assign sel_dyn     = sel_dyn_q;
  assign sr_sdata    = sdata_q;
  assign sr_shift_en = shift_en_q;
  assign sr_latch    = latch_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign stat_loaded = stat_loaded_q;

endmodule

// File: tb/tb_shiftreg_cfg_sequencer.sv
// Bench for shiftreg_cfg_sequencer: directed loads, expected words
// queued at issue time, monitor checks each sequence as it completes.
module tb_shiftreg_cfg_sequencer;

  localparam int NS = 8;
  localparam int NH = 128;
  localparam logic [87:0] D_A5  = {11{8'hA5}};
  localparam logic [87:0] D_RR  = 88'h0123456789ABCDEF012345;
  localparam logic [87:0] D_5A  = {11{8'h5A}};
  localparam logic [87:0] D_RST = 88'hFEDCBA9876543210FEDCBA;

  typedef struct {
    bit          is_stat;
    logic [87:0] data;
    int          w;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        stat_req = 1'b0;
  logic [87:0] stat_data = '0;
  logic        dyn_req = 1'b0;
  logic [15:0] dyn_data = '0;
  logic stat_ack, dyn_ack, sel_stat, sel_dyn;
  logic sr_sdata, sr_shift_en, sr_latch;
  logic busy, done, stat_loaded;

  shiftreg_cfg_sequencer dut (
    .CLK(CLK), .RST(RST),
    .stat_req(stat_req), .stat_data(stat_data),
    .stat_ack(stat_ack),
    .dyn_req(dyn_req), .dyn_data(dyn_data),
    .dyn_ack(dyn_ack),
    .sel_stat(sel_stat), .sel_dyn(sel_dyn),
    .sr_sdata(sr_sdata), .sr_shift_en(sr_shift_en),
    .sr_latch(sr_latch), .busy(busy), .done(done),
    .stat_loaded(stat_loaded)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  exp_t q[$];

  int   cyc = 0;
  int   acks = 0;
  int   dyn_acks = 0;
  int   dones = 0;
  int   last_ack_cyc = -1;
  bit   infl = 0;
  exp_t cur;
  int   t0, sel_first, sel_n, wrong_n, sh_first, nb, latch_cyc;
  logic [87:0] word;

  task automatic chk(input string nm, input logic [87:0] act,
                     input logic [87:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push(input bit s, input logic [87:0] d);
    exp_t e;
    e.is_stat = s;
    e.data    = d;
    e.w       = s ? 88 : 16;
    q.push_back(e);
  endtask

  // Monitor: samples mid-cycle, tracks one in-flight sequence.
  always @(negedge CLK) begin
    bit was;
    bit m, wr;
    exp_t e;
    cyc++;
    chk("one_sel", 88'(sel_stat & sel_dyn), 88'd0);
    chk("en_wo_sel",
        88'((sr_shift_en | sr_latch) & ~(sel_stat | sel_dyn)), 88'd0);
    if (RST) begin
      infl = 0;
    end else begin
      was = infl;
      if (was) begin
        m  = cur.is_stat ? sel_stat : sel_dyn;
        wr = cur.is_stat ? sel_dyn : sel_stat;
        if (m) begin
          if (sel_n == 0) sel_first = cyc;
          sel_n++;
        end
        if (wr) wrong_n++;
        if (sr_shift_en) begin
          if (nb == 0) sh_first = cyc;
          word = {word[86:0], sr_sdata};
          nb++;
        end
        if (sr_latch) latch_cyc = cyc;
        if (done) begin
          chki("sel_first", sel_first, t0 + 1);
          chki("sel_cycles", sel_n, NS + cur.w + 1);
          chki("wrong_sel", wrong_n, 0);
          chki("shift_first", sh_first, t0 + NS + 1);
          chki("shift_bits", nb, cur.w);
          chk("serial_word", word, cur.data);
          chki("latch_cyc", latch_cyc, t0 + NS + cur.w + 1);
          chki("done_cyc", cyc, t0 + NS + cur.w + NH + 2);
          if (cur.is_stat) chk("stat_loaded", 88'(stat_loaded), 88'd1);
          infl = 0;
          dones++;
        end
      end else if (sr_latch || done || sr_shift_en) begin
        chk("stray_activity", 88'({sr_shift_en, sr_latch, done}), 88'd0);
      end
      if (stat_ack || dyn_ack) begin
        chk("ack_both", 88'(stat_ack & dyn_ack), 88'd0);
        if (q.size() == 0) begin
          chk("unexpected_ack", 88'({stat_ack, dyn_ack}), 88'd0);
        end else begin
          e = q.pop_front();
          chk("ack_kind", 88'(stat_ack), 88'(e.is_stat));
          chki("ack_while_busy", int'(infl), 0);
          cur = e;
          infl = 1;
          t0 = cyc;
          sel_first = -1;
          sel_n = 0;
          wrong_n = 0;
          sh_first = -1;
          nb = 0;
          latch_cyc = -1;
          word = '0;
        end
        acks++;
        if (dyn_ack) dyn_acks++;
        last_ack_cyc = cyc;
      end
    end
  end

  task automatic wait_acks(input int target, input int budget);
    int n;
    n = 0;
    while (acks < target && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (acks < target) chki("ack_timeout", acks, target);
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n;
    n = 0;
    while (dones < target && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (dones < target) chki("done_timeout", dones, target);
  endtask

  function automatic logic [9:0] outs();
    return {stat_ack, dyn_ack, sel_stat, sel_dyn, sr_sdata,
            sr_shift_en, sr_latch, busy, done, stat_loaded};
  endfunction

  initial begin
    int s_ack;
    int a0, d0, da0, n;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", 88'(outs()), 88'd0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("idle_outs", 88'(outs()), 88'd0);

    // both requesters after reset: static must win first
    stat_data = D_A5;
    dyn_data  = 16'h1234;
    push(1'b1, D_A5);
    push(1'b0, 88'h1234);
    stat_req = 1'b1;
    dyn_req  = 1'b1;
    wait_acks(1, 50);
    stat_req = 1'b0;
    s_ack = last_ack_cyc;
    wait_acks(2, 400);
    dyn_req = 1'b0;
    chki("dyn_in_stat_done", last_ack_cyc, s_ack + NS + 88 + NH + 2);
    wait_dones(2, 400);
    chk("loaded_after", 88'(stat_loaded), 88'd1);

    // round-robin with both held; last grant was dynamic
    a0 = acks;
    d0 = dones;
    stat_data = D_RR;
    dyn_data  = 16'hC3A5;
    push(1'b1, D_RR);
    push(1'b0, 88'hC3A5);
    push(1'b1, D_RR);
    push(1'b0, 88'hC3A5);
    stat_req = 1'b1;
    dyn_req  = 1'b1;
    wait_acks(a0 + 4, 1200);
    stat_req = 1'b0;
    dyn_req  = 1'b0;
    wait_dones(d0 + 4, 1200);
    chki("rr_acks", acks, a0 + 4);

    // dyn request pulsed while busy must be ignored
    a0  = acks;
    d0  = dones;
    da0 = dyn_acks;
    stat_data = D_5A;
    push(1'b1, D_5A);
    stat_req = 1'b1;
    wait_acks(a0 + 1, 50);
    stat_req = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    dyn_req = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    dyn_req = 1'b0;
    wait_dones(d0 + 1, 400);
    repeat (10) @(posedge CLK);
    #1;
    chki("no_dyn_ack", dyn_acks, da0);
    chk("idle_busy", 88'(busy), 88'd0);

    // reset while shifting the static word
    a0 = acks;
    d0 = dones;
    stat_data = D_RST;
    push(1'b1, D_RST);
    stat_req = 1'b1;
    wait_acks(a0 + 1, 50);
    stat_req = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(posedge CLK);
      #1;
      if (sr_shift_en) n++;
    end
    chki("shift_seen", n, 5);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort_outs", 88'(outs()), 88'd0);
    RST = 1'b0;
    repeat (300) @(posedge CLK);
    #1;
    chki("no_done_after_abort", dones, d0);
    chk("abort_loaded", 88'(stat_loaded), 88'd0);

    // lone dynamic word 8001 from a fresh reset
    a0 = acks;
    d0 = dones;
    dyn_data = 16'h8001;
    push(1'b0, 88'h8001);
    dyn_req = 1'b1;
    wait_acks(a0 + 1, 50);
    dyn_req = 1'b0;
    wait_dones(d0 + 1, 300);
    chk("dyn_no_loaded", 88'(stat_loaded), 88'd0);
    chki("queue_empty", q.size(), 0);

    repeat (5) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
